// File: rtl/send_word_scheduler_pkg.sv
// Shared definitions for the send word scheduler: FSM encoding, byte width
// and a counter-width helper.
package send_word_scheduler_pkg;

   localparam int BYTE_W = 8;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_SEND = 1'b1;

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/send_word_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not granted last time wins. Purely combinational.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       enable,
   output logic       grant_valid,
   output logic       grant_idx
);

   // Pick the winner; the index is only meaningful while grant_valid is high.
   always_comb begin
      grant_valid = enable && (req != 2'b00);
      grant_idx   = 1'b0;
      if (req == 2'b11) begin
         grant_idx = ~last_grant;
      end else begin
         grant_idx = req[1];
      end
   end

endmodule

// File: rtl/send_word_scheduler.sv
// Shares one byte-wide UART transmitter between two word requesters.
// A granted word is sent MSB byte first; after its last byte a one-cycle
// completion strobe reports the word and the requester it came from.
module send_word_scheduler
   import send_word_scheduler_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              xreset,
   input  logic              in_valid0,
   input  logic [WORD_W-1:0] in_data0,
   output logic              in_ready0,
   input  logic              in_valid1,
   input  logic [WORD_W-1:0] in_data1,
   output logic              in_ready1,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              busy,
   output logic              send_enable,
   output logic [WORD_W-1:0] send_data,
   output logic              send_src
);

   localparam int NBYTES = WORD_W / BYTE_W;
   localparam int CNT_W  = cnt_width(NBYTES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

   state_t              state_reg;
   logic [WORD_W-1:0]   shift_reg;
   logic [WORD_W-1:0]   word_reg;
   logic                src_reg;
   logic                last_grant_reg;
   logic [CNT_W-1:0]    byte_cnt_reg;

   logic                grant_valid;
   logic                grant_idx;
   logic [WORD_W-1:0]   grant_word;
   logic                xfer;
   logic                last_xfer;

   rr_arbiter2 u_arb (
      .req         ({in_valid1, in_valid0}),
      .last_grant  (last_grant_reg),
      .enable      (state_reg == ST_IDLE),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign in_ready0  = grant_valid && !grant_idx;
   assign in_ready1  = grant_valid &&  grant_idx;
   assign grant_word = grant_idx ? in_data1 : in_data0;

   assign busy      = (state_reg == ST_SEND);
   assign tx_valid  = busy;
   assign tx_data   = busy ? shift_reg[WORD_W-1 -: BYTE_W] : 8'h00;
   assign xfer      = busy && tx_ready;
   assign last_xfer = xfer && (byte_cnt_reg == LAST_CNT);

   // Accept a granted word in IDLE, then shift it out one byte per transfer.
   always_ff @(posedge clk) begin
      if (!xreset) begin
         state_reg      <= ST_IDLE;
         shift_reg      <= '0;
         word_reg       <= '0;
         src_reg        <= 1'b0;
         last_grant_reg <= 1'b1;
         byte_cnt_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_valid) begin
                  shift_reg      <= grant_word;
                  word_reg       <= grant_word;
                  src_reg        <= grant_idx;
                  last_grant_reg <= grant_idx;
                  byte_cnt_reg   <= '0;
                  state_reg      <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (last_xfer) begin
                  state_reg <= ST_IDLE;
               end else if (xfer) begin
                  shift_reg    <= shift_reg << BYTE_W;
                  byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Completion strobe: one cycle after the final byte, reporting the word.
   always_ff @(posedge clk) begin
      if (!xreset) begin
         send_enable <= 1'b0;
         send_data   <= '0;
         send_src    <= 1'b0;
      end else begin
         send_enable <= last_xfer;
         if (last_xfer) begin
            send_data <= word_reg;
            send_src  <= src_reg;
         end
      end
   end

endmodule

// File: tb/tb_send_word_scheduler.sv
// Directed bench for send_word_scheduler: requester queues feed the DUT,
// a negedge monitor logs byte transfers and completions, and each test task
// compares the logs with hand-computed expectations.
module tb_send_word_scheduler;

   logic        clk = 1'b0;
   logic        xreset;
   logic        in_valid0, in_valid1, tx_ready;
   logic [31:0] in_data0, in_data1;
   logic        in_ready0, in_ready1, tx_valid, busy, send_enable, send_src;
   logic [7:0]  tx_data;
   logic [31:0] send_data;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [7:0]  tx_q[$];
   int          tx_cyc_q[$];
   logic [31:0] cmp_data_q[$];
   logic        cmp_src_q[$];
   int          cmp_cyc_q[$];

   int   cyc = 0;
   int   acc_cyc = 0;
   int   acc0_cnt = 0;
   int   acc1_cnt = 0;
   int   stall_err = 0;
   bit   acc0 = 1'b0;
   bit   acc1 = 1'b0;
   bit   prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always #5 clk = ~clk;

   send_word_scheduler #(.WORD_W(32)) dut (
      .clk         (clk),
      .xreset      (xreset),
      .in_valid0   (in_valid0),
      .in_data0    (in_data0),
      .in_ready0   (in_ready0),
      .in_valid1   (in_valid1),
      .in_data1    (in_data1),
      .in_ready1   (in_ready1),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .send_enable (send_enable),
      .send_data   (send_data),
      .send_src    (send_src)
   );

   // Monitor: sample outputs mid-cycle, ahead of the edge that acts on them.
   always @(negedge clk) begin
      cyc++;
      if (xreset && tx_valid && tx_ready) begin
         tx_q.push_back(tx_data);
         tx_cyc_q.push_back(cyc);
      end
      if (send_enable) begin
         cmp_data_q.push_back(send_data);
         cmp_src_q.push_back(send_src);
         cmp_cyc_q.push_back(cyc);
      end
      acc0 = xreset && in_valid0 && in_ready0;
      acc1 = xreset && in_valid1 && in_ready1;
      if (acc0) acc0_cnt++;
      if (acc1) acc1_cnt++;
      if (acc0 || acc1) acc_cyc = cyc;
      if (xreset && prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
      prev_stall = xreset && tx_valid && !tx_ready;
      prev_data  = tx_data;
   end

   // Requester model: hold the head word until it is accepted, then move on.
   always @(posedge clk) begin
      #1;
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      in_valid0 = (q0.size() != 0);
      in_data0  = (q0.size() != 0) ? q0[0] : 32'h0;
      in_valid1 = (q1.size() != 0);
      in_data1  = (q1.size() != 0) ? q1[0] : 32'h0;
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic clear_logs();
      tx_q.delete();
      tx_cyc_q.delete();
      cmp_data_q.delete();
      cmp_src_q.delete();
      cmp_cyc_q.delete();
      acc0_cnt  = 0;
      acc1_cnt  = 0;
      stall_err = 0;
   endtask

   task automatic do_reset();
      xreset = 1'b0;
      repeat (2) tick();
      xreset = 1'b1;
   endtask

   task automatic wait_cmp(input int n, input int budget);
      for (int i = 0; i < budget && cmp_data_q.size() < n; i++) tick();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      tx_ready = 1'b1;
      xreset   = 1'b0;
      repeat (2) tick();
      vectors++;
      if ({tx_valid, busy, send_enable, send_src} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got tx_valid/busy/send_enable/send_src=%b, want 0000",
                  {tx_valid, busy, send_enable, send_src});
      end
      vectors++;
      if (tx_data !== 8'h00 || send_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data: got tx_data=%h send_data=%h, want 00 00000000", tx_data, send_data);
      end
      xreset = 1'b1;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_single();
      logic [7:0] exp_b [4] = '{8'h00, 8'h00, 8'h00, 8'h69};
      clear_logs();
      q0.push_back(32'h0000_0069);
      wait_cmp(1, 30);
      vectors++;
      if (cmp_data_q.size() != 1 || tx_q.size() != 4 || acc0_cnt != 1) begin
         miscompares++;
         $display("FAIL single_counts: got cmp=%0d bytes=%0d acc0=%0d, want 1 4 1",
                  cmp_data_q.size(), tx_q.size(), acc0_cnt);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_q[i] !== exp_b[i] || tx_cyc_q[i] != acc_cyc + 1 + i) begin
               miscompares++;
               $display("FAIL single_byte%0d: got %h at cycle %0d, want %h at cycle %0d",
                        i, tx_q[i], tx_cyc_q[i], exp_b[i], acc_cyc + 1 + i);
            end
         end
         vectors++;
         if (cmp_data_q[0] !== 32'd105 || cmp_src_q[0] !== 1'b0 || cmp_cyc_q[0] != tx_cyc_q[3] + 1) begin
            miscompares++;
            $display("FAIL single_done: got data=%0d src=%b cyc=%0d, want 105 0 %0d",
                     cmp_data_q[0], cmp_src_q[0], cmp_cyc_q[0], tx_cyc_q[3] + 1);
         end
      end
      $display("test_single: word 00000069 bytes=%0d completions=%0d", tx_q.size(), cmp_data_q.size());
   endtask

   task automatic test_tie();
      logic [7:0] exp_b [8] = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h12, 8'h34, 8'h56, 8'h78};
      do_reset();
      clear_logs();
      q0.push_back(32'd7);
      q1.push_back(32'h1234_5678);
      wait_cmp(2, 40);
      vectors++;
      if (cmp_data_q.size() != 2 || tx_q.size() != 8 || acc0_cnt != 1 || acc1_cnt != 1) begin
         miscompares++;
         $display("FAIL tie_counts: got cmp=%0d bytes=%0d acc0=%0d acc1=%0d, want 2 8 1 1",
                  cmp_data_q.size(), tx_q.size(), acc0_cnt, acc1_cnt);
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (tx_q[i] !== exp_b[i]) begin
               miscompares++;
               $display("FAIL tie_byte%0d: got %h, want %h", i, tx_q[i], exp_b[i]);
            end
         end
         vectors++;
         if (cmp_data_q[0] !== 32'd7 || cmp_src_q[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_first: got data=%h src=%b, want 00000007 0", cmp_data_q[0], cmp_src_q[0]);
         end
         vectors++;
         if (cmp_data_q[1] !== 32'h1234_5678 || cmp_src_q[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_second: got data=%h src=%b, want 12345678 1", cmp_data_q[1], cmp_src_q[1]);
         end
         vectors++;
         if (tx_cyc_q[4] != cmp_cyc_q[0] + 1) begin
            miscompares++;
            $display("FAIL tie_back_to_back: got second word start cycle %0d, want %0d",
                     tx_cyc_q[4], cmp_cyc_q[0] + 1);
         end
      end
      $display("test_tie: completions=%0d bytes=%0d", cmp_data_q.size(), tx_q.size());
   endtask

   task automatic test_stall();
      logic [7:0] exp_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      clear_logs();
      tx_ready = 1'b0;
      q0.push_back(32'hA1B2_C3D4);
      for (int i = 0; i < 10 && !tx_valid; i++) tick();
      for (int i = 0; i < 7; i++) begin
         tx_ready = pat[i];
         tick();
      end
      tx_ready = 1'b1;
      wait_cmp(1, 20);
      vectors++;
      if (tx_q.size() != 4 || cmp_data_q.size() != 1 || stall_err != 0) begin
         miscompares++;
         $display("FAIL stall_counts: got bytes=%0d cmp=%0d unstable=%0d, want 4 1 0",
                  tx_q.size(), cmp_data_q.size(), stall_err);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_q[i] !== exp_b[i]) begin
               miscompares++;
               $display("FAIL stall_byte%0d: got %h, want %h", i, tx_q[i], exp_b[i]);
            end
         end
         vectors++;
         if (cmp_data_q[0] !== 32'hA1B2_C3D4 || cmp_src_q[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done: got data=%h src=%b, want a1b2c3d4 0", cmp_data_q[0], cmp_src_q[0]);
         end
      end
      $display("test_stall: bytes=%0d completions=%0d", tx_q.size(), cmp_data_q.size());
   endtask

   task automatic test_repeat();
      clear_logs();
      q0.push_back(32'd1);
      q0.push_back(32'd2);
      q0.push_back(32'd3);
      wait_cmp(3, 60);
      vectors++;
      if (cmp_data_q.size() != 3 || acc0_cnt != 3 || acc1_cnt != 0) begin
         miscompares++;
         $display("FAIL repeat_counts: got cmp=%0d acc0=%0d acc1=%0d, want 3 3 0",
                  cmp_data_q.size(), acc0_cnt, acc1_cnt);
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cmp_data_q[i] !== 32'(i + 1) || cmp_src_q[i] !== 1'b0) begin
               miscompares++;
               $display("FAIL repeat_word%0d: got data=%0d src=%b, want %0d 0",
                        i, cmp_data_q[i], cmp_src_q[i], i + 1);
            end
         end
         vectors++;
         if (cmp_cyc_q[1] - cmp_cyc_q[0] != 5 || cmp_cyc_q[2] - cmp_cyc_q[1] != 5) begin
            miscompares++;
            $display("FAIL repeat_period: got %0d and %0d cycles between words, want 5 5",
                     cmp_cyc_q[1] - cmp_cyc_q[0], cmp_cyc_q[2] - cmp_cyc_q[1]);
         end
      end
      $display("test_repeat: completions=%0d", cmp_data_q.size());
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_b [10] = '{8'hDE, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h55};
      clear_logs();
      tx_ready = 1'b1;
      q0.push_back(32'hDEAD_BEEF);
      for (int i = 0; i < 20 && tx_q.size() < 2; i++) tick();
      xreset = 1'b0;
      tick();
      vectors++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_drop: got tx_valid=%b busy=%b, want 0 0", tx_valid, busy);
      end
      xreset = 1'b1;
      repeat (8) tick();
      vectors++;
      if (cmp_data_q.size() != 0 || tx_q.size() != 2) begin
         miscompares++;
         $display("FAIL midreset_abandon: got cmp=%0d bytes=%0d, want 0 2", cmp_data_q.size(), tx_q.size());
      end
      q0.push_back(32'h0);
      q1.push_back(32'h55);
      wait_cmp(2, 40);
      vectors++;
      if (cmp_data_q.size() != 2 || tx_q.size() != 10) begin
         miscompares++;
         $display("FAIL midreset_counts: got cmp=%0d bytes=%0d, want 2 10", cmp_data_q.size(), tx_q.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            vectors++;
            if (tx_q[i] !== exp_b[i]) begin
               miscompares++;
               $display("FAIL midreset_byte%0d: got %h, want %h", i, tx_q[i], exp_b[i]);
            end
         end
         vectors++;
         if (cmp_data_q[0] !== 32'h0 || cmp_src_q[0] !== 1'b0 ||
             cmp_data_q[1] !== 32'h55 || cmp_src_q[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_words: got %h/%b then %h/%b, want 00000000/0 then 00000055/1",
                     cmp_data_q[0], cmp_src_q[0], cmp_data_q[1], cmp_src_q[1]);
         end
      end
      $display("test_reset_mid: completions=%0d bytes=%0d", cmp_data_q.size(), tx_q.size());
   endtask

   initial begin
      xreset    = 1'b0;
      tx_ready  = 1'b0;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      in_data0  = 32'h0;
      in_data1  = 32'h0;
      test_reset();
      test_single();
      test_tie();
      test_stall();
      test_repeat();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/send_word_scheduler.md
Name: send_word_scheduler

Overview:
- Shares the single byte-wide UART transmitter between two 32-bit word requesters: CPU output port and the debug/monitor path.
- Requester 0 is the CPU output port. Requester 1 is the debug/monitor path.
- Arbitrates round-robin, serialises each accepted word MSB-first into bytes, and drives the transmitter via valid/ready.
- Emits a one-cycle send_enable/send_data completion strobe per finished word; top-level benches check this strobe.

Parameters:
- WORD_W, 32, requester word width; must be a multiple of 8.
- NBYTES, WORD_W/8, bytes sent per word (derived; not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- xreset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid0  in  1  requester 0 has a word.
- in_data0  in  WORD_W  requester 0 word.
- in_ready0  out  1  requester 0 word accepted this cycle (combinational).
- in_valid1  in  1  requester 1 has a word.
- in_data1  in  WORD_W  requester 1 word.
- in_ready1  out  1  requester 1 word accepted this cycle (combinational).
- tx_valid  out  1  byte offered to UART transmitter.
- tx_data  out  8  byte value.
- tx_ready  in  1  transmitter can take a byte; a transfer happens when tx_valid && tx_ready.
- busy  out  1  high while a word is in flight (state SEND).
- send_enable  out  1  one-cycle pulse after the last byte of a word is transferred.
- send_data  out  WORD_W  completed word; valid while send_enable=1, holds last value otherwise.
- send_src  out  1  requester index of the completed word.

Behaviour:
- Reset (xreset=0 at an edge):
  - state=IDLE, tx_valid=0, tx_data=0, busy=0, send_enable=0, send_data=0, send_src=0, byte_cnt=0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE and SEND.
- IDLE:
  - Grant rule:
    - If only one in_valid is high, grant that requester.
    - If both are high, grant the requester != last_grant.
    - Otherwise no grant.
  - in_ready of the granted requester is 1 in the same cycle; in_ready is 0 for any requester in SEND.
  - On grant at edge N:
    - Latch the word into shift_reg and set src=grant, last_grant=grant, byte_cnt=0, state=SEND.
    - tx_valid=1 and tx_data=word[WORD_W-1:WORD_W-8] take effect at N+1.
- SEND:
  - tx_valid=1; tx_data=shift_reg top byte, held stable while tx_ready=0.
  - On a transfer with byte_cnt<NBYTES-1: shift_reg <<= 8, byte_cnt++, next byte presented the following cycle.
  - On a transfer with byte_cnt==NBYTES-1:
    - state=IDLE, tx_valid=0.
    - send_enable=1 for exactly one cycle, with send_data=original word and send_src=src.
  - Minimum word time: NBYTES cycles in SEND (tx_ready held 1), plus 1 accept cycle.
- Back-to-back: a new grant may occur in the cycle the completion pulse is high; no idle gap is required beyond the IDLE accept cycle.
- A single persistent requester is granted repeatedly. Alternation is forced only on ties.
- Word value 0 is not special; it is transmitted and reported like any other.
- in_valid inputs changing mid-word have no effect; a requester holds its word until in_ready.
- Reset mid-word: the partial word is abandoned at the reset edge. tx_valid drops and no send_enable is produced. After reset, arbitration restarts with requester 0 priority.
- tx_ready while tx_valid=0 is ignored.

Decomposition:
- Shared package: state encoding (IDLE, SEND) and the BYTE_W=8 constant.
- Sub-module rr_arbiter2:
  - Inputs: req[1:0], last_grant, enable.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational.
  - Used by this block and reusable for future shared-port arbitration.

Test Plan:
- Reset, then in_valid0=1, in_data0=0x00000069, tx_ready=1 → in_ready0 pulses once; tx_data bytes 00,00,00,69 on 4 consecutive cycles; then send_enable=1 with send_data=105, send_src=0.
- Both valid from reset: in_data0=7, in_data1=0x12345678, both held until accepted → req0 served first (7 reported, src 0), then req1 (bytes 12,34,56,78, src 1).
- Stall: tx_ready toggles 1,0,0,1,0,1,1 during a word 0xA1B2C3D4 → each byte is held stable while stalled; exactly four transfers A1,B2,C3,D4; one send_enable.
- Repeated requester: in_valid0 held high with words 1,2,3, in_valid1=0 → three consecutive grants to requester 0; send_enable pulses report 1,2,3, all src 0.
- Reset mid-word: xreset=0 after the second byte of 0xDEADBEEF → next cycle tx_valid=0 and busy=0; no send_enable; a following word 0 completes with send_data=0, send_src=0.
